// File: rtl/sysu_not_pipe_if.sv
// Producer/consumer bus for the sysu_not_pipe stallable inverter pipeline.
interface sysu_not_pipe_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
);
    localparam int unsigned OCC_W = $clog2(STAGES + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] inv_mask;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [OCC_W-1:0] occupancy;

    // master: producer/consumer side; slave: the pipeline itself
    modport master (
        output in_valid, in_data, inv_mask, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  in_valid, in_data, inv_mask, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/sysu_not_pipe.sv
// WIDTH-bit, STAGES-deep registered bus inverter with valid/ready back-pressure.
// Per-lane mask is applied once at entry; later stages only move data.
module sysu_not_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2,
    parameter int          DELAY  = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    sysu_not_pipe_if.slave bus
);
    localparam int unsigned OCC_W = $clog2(STAGES + 1);
    localparam int unsigned LAST  = STAGES - 1;

    if (WIDTH < 1 || STAGES < 1 || DELAY < 0) begin : g_param_check
        $error("sysu_not_pipe: WIDTH and STAGES must be >= 1, DELAY >= 0");
    end

    logic [STAGES-1:0]            valid_q;
    logic [STAGES-1:0][WIDTH-1:0] data_q;
    logic [OCC_W-1:0]             occ_q;
    logic [STAGES-1:0]            load_c;
    logic                         in_accept_c;
    logic                         out_accept_c;

    // A stage loads when empty or when its content moves on this cycle.
    always_comb begin
        load_c       = '0;
        load_c[LAST] = !valid_q[LAST] || bus.out_ready;
        for (int i = int'(LAST) - 1; i >= 0; i--) begin
            load_c[i] = !valid_q[i] || load_c[i+1];
        end
        in_accept_c  = bus.in_valid && load_c[0];
        out_accept_c = valid_q[LAST] && bus.out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
            occ_q   <= '0;
        end else begin
            if (load_c[0]) begin
                valid_q[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    data_q[0] <= bus.in_data ^ bus.inv_mask;
                end
            end
            // Data only moves behind a valid beat so held outputs stay stable.
            for (int i = 1; i < int'(STAGES); i++) begin
                if (load_c[i]) begin
                    valid_q[i] <= valid_q[i-1];
                    if (valid_q[i-1]) begin
                        data_q[i] <= data_q[i-1];
                    end
                end
            end
            occ_q <= occ_q + OCC_W'(in_accept_c) - OCC_W'(out_accept_c);
        end
    end

    assign bus.in_ready  = load_c[0];
    assign bus.out_valid = valid_q[LAST];
    assign bus.out_data  = data_q[LAST];
    assign bus.occupancy = occ_q;
endmodule
